// File: rtl/div_pkg.sv
// Shared types for the radix-2 restoring divider: FSM states, result record
// and the fixed error-result pattern.
package div_pkg;

   localparam int DIV_N = 8;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   typedef struct packed {
      logic [DIV_N-1:0] quotient;
      logic [DIV_N-1:0] remainder;
      logic             div0;
      logic             ovf;
   } div_result_t;

   // Saturated quotient, zero remainder; exactly one of div0/ovf set.
   function automatic div_result_t err_result(input logic is_div0);
      div_result_t res;
      res.quotient  = '1;
      res.remainder = '0;
      res.div0      = is_div0;
      res.ovf       = ~is_div0;
      return res;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left by one, trial
// subtract the divisor, keep the difference and set Q[0] when it is non-negative.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N-1:0] r,
   input  logic [N-1:0] q,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] r_next,
   output logic [N-1:0] q_next
);

   logic [N:0] r_sh;
   logic [N:0] t;

   // r < divisor on entry, so r_sh < 2*divisor and t[N] is the trial sign.
   always_comb begin
      r_sh = {r, q[N-1]};
      t    = r_sh - {1'b0, divisor};
      if (!t[N]) begin
         r_next = t[N-1:0];
         q_next = {q[N-2:0], 1'b1};
      end else begin
         r_next = r_sh[N-1:0];
         q_next = {q[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/radix2_divider.sv
// Sequential restoring divider, 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, valid/ready on both sides. `DIVIDER_SIGNED_EN selects two's complement.
module radix2_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div0,
   output logic           ovf
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   div_state_t     state, state_next;
   // R[N] is always zero between steps, so only the low N bits of R are held.
   logic [N-1:0]   r_q;
   logic [N-1:0]   q_q;
   logic [N-1:0]   dv_q;
   logic [CW-1:0]  count;
   div_result_t    res;
   div_result_t    done_res;

   logic [N-1:0]   r_step;
   logic [N-1:0]   q_step;
   logic [2*N-1:0] op_dd;
   logic [N-1:0]   op_dv;
   logic           accept;
   logic           last;
   logic           err_div0;
   logic           err_ovf;

`ifdef DIVIDER_SIGNED_EN
   localparam logic [N-1:0] LIM_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] LIM_NEG = {1'b1, {(N-1){1'b0}}};

   logic neg_q, neg_r;
   logic neg_q_q, neg_r_q;

   always_comb begin
      neg_r = dividend[2*N-1];
      neg_q = dividend[2*N-1] ^ divisor[N-1];
      op_dd = neg_r ? -dividend : dividend;
      op_dv = divisor[N-1] ? -divisor : divisor;
   end

   always_comb begin
      done_res.div0 = 1'b0;
      done_res.ovf  = neg_q_q ? (q_step > LIM_NEG) : (q_step > LIM_POS);
      if (done_res.ovf) begin
         done_res.quotient  = '1;
         done_res.remainder = '0;
      end else begin
         done_res.quotient  = neg_q_q ? -q_step : q_step;
         done_res.remainder = neg_r_q ? -r_step : r_step;
      end
   end
`else
   always_comb begin
      op_dd = dividend;
      op_dv = divisor;
   end

   always_comb begin
      done_res.quotient  = q_step;
      done_res.remainder = r_step;
      done_res.div0      = 1'b0;
      done_res.ovf       = 1'b0;
   end
`endif

   always_comb begin
      accept   = in_valid && (state == IDLE);
      last     = (count == CW'(N-1));
      err_div0 = (op_dv == '0);
      err_ovf  = !err_div0 && (op_dd[2*N-1:N] >= op_dv);
   end

   div_step #(
      .N(N)
   ) u_step (
      .r       (r_q),
      .q       (q_q),
      .divisor (dv_q),
      .r_next  (r_step),
      .q_next  (q_step)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      quotient   = res.quotient;
      remainder  = res.remainder;
      div0       = res.div0;
      ovf        = res.ovf;
      unique case (state)
         IDLE:    if (accept) state_next = (err_div0 || err_ovf) ? DONE : CALC;
         CALC:    if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q     <= '0;
         q_q     <= '0;
         dv_q    <= '0;
         count   <= '0;
         res     <= '0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  r_q   <= op_dd[2*N-1:N];
                  q_q   <= op_dd[N-1:0];
                  dv_q  <= op_dv;
                  count <= '0;
`ifdef DIVIDER_SIGNED_EN
                  neg_q_q <= neg_q;
                  neg_r_q <= neg_r;
`endif
                  if (err_div0 || err_ovf) res <= err_result(err_div0);
               end
            end
            CALC: begin
               r_q   <= r_step;
               q_q   <= q_step;
               count <= count + 1'b1;
               if (last) res <= done_res;
            end
            DONE: begin
               if (out_ready) res <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: constant and random vector table
// against an arithmetic reference model, plus backpressure and reset sequences.
module tb_radix2_divider;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        in_ready, out_valid, div0, ovf;
   logic [7:0]  quotient, remainder;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   radix2_divider #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div0      (div0),
      .ovf       (ovf)
   );

   typedef struct {
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        d0;
      logic        ov;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain integer division, range check on the true quotient.
   function automatic vec_t model(input logic [15:0] dd, input logic [7:0] dv);
      vec_t v;
      int a, b, qm, rm, lim;
      bit neg_q, neg_r;
      v.dd = dd; v.dv = dv; v.d0 = 1'b0; v.ov = 1'b0; v.q = '0; v.r = '0;
`ifdef DIVIDER_SIGNED_EN
      a = int'($signed(dd));
      b = int'($signed(dv));
      neg_q = (a < 0) != (b < 0);
      neg_r = (a < 0);
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      lim = neg_q ? 128 : 127;
`else
      a = int'(dd);
      b = int'(dv);
      neg_q = 1'b0;
      neg_r = 1'b0;
      lim = 255;
`endif
      if (b == 0) begin
         v.d0 = 1'b1; v.q = 8'hFF; v.r = 8'h00; v.lat = 1;
      end else begin
         qm = a / b;
         rm = a % b;
         v.lat = (qm >= 256) ? 1 : N + 1;
         if (qm > lim) begin
            v.ov = 1'b1; v.q = 8'hFF; v.r = 8'h00;
         end else begin
            v.q = 8'(neg_q ? -qm : qm);
            v.r = 8'(neg_r ? -rm : rm);
         end
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      bit seen;
      @(negedge clk);
      chk($sformatf("%s.in_ready", tag), in_ready, 1);
      in_valid = 1'b1; dividend = v.dd; divisor = v.dv;
      @(posedge clk);
      #1 in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
      end
      chk($sformatf("%s.latency", tag), seen ? lat : -1, v.lat);
      chk($sformatf("%s.q", tag), quotient, v.q);
      chk($sformatf("%s.r", tag), remainder, v.r);
      chk($sformatf("%s.div0", tag), div0, v.d0);
      chk($sformatf("%s.ovf", tag), ovf, v.ov);
   endtask

   initial begin
      vec_t v;
      logic [15:0] rdd;
      logic [7:0]  rdv;
      int lat;
      bit seen;

`ifdef DIVIDER_SIGNED_EN
      vecs.push_back('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9});
      vecs.push_back('{16'hFF80, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 9});
      vecs.push_back('{16'd50,   8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{16'h0800, 8'h04, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
      vecs.push_back('{16'd100,  8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9});
      vecs.push_back('{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9});
      vecs.push_back('{16'h0080, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 9});
      vecs.push_back('{16'hFFFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0, 9});
      vecs.push_back('{16'd9,    8'd3,  8'd3,  8'd0,  1'b0, 1'b0, 9});
`else
      vecs.push_back('{16'd1000, 8'd7,  8'd142, 8'd6, 1'b0, 1'b0, 9});
      vecs.push_back('{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9});
      vecs.push_back('{16'd50,   8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{16'h0800, 8'h04, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
      vecs.push_back('{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9});
      vecs.push_back('{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9});
      vecs.push_back('{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
      vecs.push_back('{16'd9,    8'd3,  8'd3,  8'd0,  1'b0, 1'b0, 9});
      vecs.push_back('{16'hFFFF, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1});
`endif
      for (int i = 0; i < 40; i++) begin
         rdv = 8'($urandom);
         if (i % 11 == 0) rdv = 8'h00;
         case (i % 3)
            0:       rdd = 16'($urandom);
            1:       rdd = 16'($urandom) >> $urandom_range(0, 15);
            default: rdd = 16'(int'(rdv) * $urandom_range(0, 255) + $urandom_range(0, int'(rdv)));
         endcase
         vecs.push_back(model(rdd, rdv));
      end

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.in_ready", in_ready, 1);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.q", quotient, 0);
      chk("reset.r", remainder, 0);
      chk("reset.div0", div0, 0);
      chk("reset.ovf", ovf, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held for 5 cycles, in_valid ignored in CALC/DONE
      v = model(16'd1000, 8'd7);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
      @(posedge clk);
      #1 dividend = 16'd9; divisor = 8'd3;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
      end
      chk("hold.latency", seen ? lat : -1, v.lat);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d.out_valid", k), out_valid, 1);
         chk($sformatf("hold%0d.in_ready", k), in_ready, 0);
         chk($sformatf("hold%0d.q", k), quotient, v.q);
         chk($sformatf("hold%0d.r", k), remainder, v.r);
         chk($sformatf("hold%0d.ovf", k), ovf, v.ov);
         @(negedge clk);
      end
      chk("hold.still_valid", out_valid, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release.out_valid", out_valid, 0);
      chk("release.in_ready", in_ready, 1);
      chk("release.q", quotient, 0);
      chk("release.r", remainder, 0);
      chk("release.ovf", ovf, 0);
      run_op(model(16'd100, 8'd10), "after_hold");

      // Reset during CALC aborts the division
      @(negedge clk);
      in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort.out_valid", out_valid, 0);
      chk("abort.in_ready", in_ready, 1);
      chk("abort.q", quotient, 0);
      chk("abort.r", remainder, 0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort.no_result", seen, 0);
      run_op(model(16'd9, 8'd3), "after_abort");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
